// File: rtl/ahbm_arbiter.sv
// Round-robin arbiter sharing one single-outstanding AHB master command port among NREQ requesters.
// Optional WAIT-state watchdog abort is enabled by defining AHBM_ARB_TIMEOUT_EN.
module ahbm_arbiter #(
  parameter int NREQ           = 2,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 HCLK,
  input  logic                 HRESETN,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [NREQ-1:0]      req_write_i,
  input  logic [NREQ*AW-1:0]   req_addr_i,
  input  logic [NREQ*DW-1:0]   req_wdata_i,
  output logic [NREQ-1:0]      req_ready_o,
  output logic [NREQ-1:0]      rsp_valid_o,
  output logic [DW-1:0]        rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic                 m_valid_o,
  output logic                 m_write_o,
  output logic [AW-1:0]        m_addr_o,
  output logic [DW-1:0]        m_wdata_o,
  input  logic                 m_done_i,
  input  logic [DW-1:0]        m_rdata_i,
  input  logic                 m_err_i,
  output logic                 busy_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     win_q;
  logic [PW-1:0]     pick_s, cand_s;
  logic              pick_vld_s;
  logic              sel_write_s;
  logic [AW-1:0]     sel_addr_s;
  logic [DW-1:0]     sel_wdata_s;
  logic              timeout_s;

  logic [NREQ-1:0]   req_ready_q, rsp_valid_q;
  logic [DW-1:0]     rsp_rdata_q;
  logic              rsp_err_q;
  logic              m_valid_q, m_write_q;
  logic [AW-1:0]     m_addr_q;
  logic [DW-1:0]     m_wdata_q;
  logic              busy_q;

  // Descending offset scan so the requester closest to rr_ptr (lowest offset) is the last to overwrite.
  always_comb begin
    pick_vld_s = 1'b0;
    pick_s     = '0;
    cand_s     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand_s = PW'((int'(rr_ptr_q) + k) % NREQ);
      for (int j = 0; j < NREQ; j++) begin
        if ((cand_s == PW'(j)) && req_valid_i[j]) begin
          pick_vld_s = 1'b1;
          pick_s     = cand_s;
        end else begin
          pick_vld_s = pick_vld_s;
        end
      end
    end
  end

  always_comb begin
    sel_write_s = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (pick_s == PW'(j)) begin
        sel_write_s = req_write_i[j];
        sel_addr_s  = req_addr_i[j*AW +: AW];
        sel_wdata_s = req_wdata_i[j*DW +: DW];
      end else begin
        sel_write_s = sel_write_s;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      S_IDLE:  state_d = pick_vld_s ? S_ISSUE : S_IDLE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  state_d = (m_done_i || timeout_s) ? S_RESP : S_WAIT;
      S_RESP: begin
        state_d  = S_IDLE;
        rr_ptr_d = PW'((int'(win_q) + 1) % NREQ);
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef AHBM_ARB_TIMEOUT_EN
  logic [15:0] to_cnt_q;

  assign timeout_s = (state_q == S_WAIT) && ((to_cnt_q + 16'd1) == 16'(TIMEOUT_CYCLES));

  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      to_cnt_q <= 16'd0;
    end else if (state_q == S_ISSUE) begin
      to_cnt_q <= 16'd0;
    end else if (state_q == S_WAIT) begin
      to_cnt_q <= to_cnt_q + 16'd1;
    end else begin
      to_cnt_q <= to_cnt_q;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      win_q       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      m_write_q   <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      m_valid_q   <= 1'b0;
      busy_q      <= (state_d != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (pick_vld_s) begin
            win_q       <= pick_s;
            req_ready_q <= NREQ'(1'b1) << pick_s;
            m_write_q   <= sel_write_s;
            m_addr_q    <= sel_addr_s;
            m_wdata_q   <= sel_wdata_s;
          end
        end
        S_ISSUE: m_valid_q <= 1'b1;
        S_WAIT: begin
          // Completion beats the watchdog when both land on the same cycle.
          if (m_done_i) begin
            rsp_valid_q <= NREQ'(1'b1) << win_q;
            rsp_rdata_q <= m_write_q ? '0 : m_rdata_i;
            rsp_err_q   <= m_err_i;
          end else if (timeout_s) begin
            rsp_valid_q <= NREQ'(1'b1) << win_q;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign m_valid_o   = m_valid_q;
  assign m_write_o   = m_write_q;
  assign m_addr_o    = m_addr_q;
  assign m_wdata_o   = m_wdata_q;
  assign busy_o      = busy_q;

endmodule

// File: doc/ahbm_arbiter.md
Name: ahbm_arbiter

Overview:
- Shares the single-outstanding AHB master user command port between NREQ independent requesters, e.g. the I2C register bridge and a config/boot sequencer.
- Round-robin arbitration. The winning command is latched, presented downstream, and its completion is waited for. The read data/response is then routed back to the granted requester.
- Sits between the requesters and the AHB master wrapper's user interface, in the HCLK domain.

Parameters:
NREQ, 2, number of requesters (2..4)
AW, 32, address width
DW, 32, data width
TIMEOUT_CYCLES, 255, WAIT-state cycles before watchdog abort (used only with the optional feature)

Ports:
HCLK  input  1  system clock; all logic on rising edge
HRESETN  input  1  reset, synchronous, active-low
req_valid_i  input  NREQ  per-requester command valid, level, held until accepted
req_write_i  input  NREQ  1=write, 0=read
req_addr_i  input  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
req_wdata_i  input  NREQ*DW  packed write data
req_ready_o  output  NREQ  one-cycle accept pulse, one-hot
rsp_valid_o  output  NREQ  one-cycle completion pulse, one-hot, to the granted requester
rsp_rdata_o  output  DW  read data, valid with rsp_valid_o
rsp_err_o  output  1  error flag, valid with rsp_valid_o
m_valid_o  output  1  downstream command strobe, one cycle
m_write_o  output  1  downstream direction
m_addr_o  output  AW  downstream address
m_wdata_o  output  DW  downstream write data
m_done_i  input  1  downstream completion pulse (data phase finished)
m_rdata_i  input  DW  downstream read data, valid with m_done_i
m_err_i  input  1  downstream HRESP error, valid with m_done_i
busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset (HRESETN low at HCLK edge):
  - state=IDLE, rr_ptr=0.
  - All outputs 0: req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, m_valid_o, m_write_o, m_addr_o, m_wdata_o, busy_o.
  - Reset mid-transaction abandons the command silently; no rsp_valid_o is issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid_i: winner = first set bit searching from rr_ptr upward, wrapping modulo NREQ.
  - Latch winner index, write, addr, wdata. Pulse req_ready_o[winner] in the same registered cycle as the move to ISSUE.
  - No valid: stay in IDLE.
- ISSUE:
  - m_valid_o=1 for exactly one cycle; m_write_o/m_addr_o/m_wdata_o driven from the latch.
  - Next state WAIT.
- WAIT:
  - m_addr_o/m_write_o/m_wdata_o held stable; m_valid_o=0.
  - On m_done_i: capture m_rdata_i into rsp_rdata_o (writes capture 0) and m_err_i into rsp_err_o; next state RESP.
- RESP:
  - rsp_valid_o[winner]=1 for one cycle; rr_ptr <= (winner+1) mod NREQ; next state IDLE.
- Latency:
  - req_valid edge in IDLE to req_ready: 1 cycle.
  - req_ready to m_valid: 1 cycle.
  - m_done to rsp_valid: 1 cycle.
  - Minimum turnaround between back-to-back grants: 4 cycles.
- Boundaries:
  - Simultaneous requests: rr_ptr decides; requester i cannot win twice in a row while another is pending.
  - req_valid_i may drop after req_ready; the latched command is unaffected.
  - req_valid_i dropping before grant withdraws the request.
  - m_done_i outside WAIT is ignored.
  - rsp_rdata_o and rsp_err_o hold their values until the next capture.
  - NREQ=1 degenerates to a pass-through sequencer with rr_ptr fixed at 0.

Optional Feature:
Macro AHBM_ARB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without m_done_i, go to RESP with rsp_rdata_o=0 and rsp_err_o=1.
  - m_done_i arriving on the same cycle as the limit wins (normal completion).
- Not defined: no counter; WAIT holds indefinitely until m_done_i.

Test Plan:
- Single read, requester 0, addr 0x4000_0010:
  - req_ready_o=01 at cycle 1, m_valid_o at cycle 2.
  - m_done_i with m_rdata_i=0xDEADBEEF -> next cycle rsp_valid_o=01, rsp_rdata_o=0xDEADBEEF, rsp_err_o=0.
- Both requesters held valid continuously, four transactions: grants alternate 0,1,0,1; each m_addr_o matches its owner's address.
- Write from requester 1, data 0x1234_5678, requester drops req_valid_i after req_ready:
  - m_write_o=1, m_wdata_o=0x12345678 stable through WAIT.
  - rsp_valid_o=10, rsp_rdata_o=0.
- m_err_i=1 with m_done_i -> rsp_err_o=1 for that response only; the next clean transaction returns rsp_err_o=0.
- HRESETN driven low during WAIT:
  - All outputs 0 after the edge; no rsp_valid_o; rr_ptr=0.
  - A fresh request is served normally.
- With AHBM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, m_done_i never asserted -> rsp_valid_o after 8 WAIT cycles, rsp_err_o=1, rsp_rdata_o=0, busy_o falls the next cycle.
